stream_out_mux: RTL and testbench

- Per-slave-port output stage of the stream crossbar, directly downstream of the round-robin arbiter.
- Takes the arbiter's grant (id, ready) and locks onto the granted master for one whole packet.
- Routes that master's beats to the slave port through a 2-entry registered skid buffer.
- Returns a one-hot per-master last pulse to the arbiter so it can rotate to the next master.

---
 rtl/stream_out_mux.sv | 154 +++++++++++++++
 tb/tb_stream_out_mux.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_out_mux.sv
// Per-slave-port output stage: locks onto the arbiter's granted master for one packet and
// forwards its beats through a 2-entry registered skid buffer. Optional lock watchdog:
// define STREAM_OUT_MUX_WATCHDOG_EN to add the idle timeout and the sticky err_o flag.
//
// state | meaning
// IDLE  | no lock held; inputs not ready; waits for grant_valid_i
// LOCK  | forwarding lock_id_q's packet until its tlast beat is accepted
module stream_out_mux #(
  parameter int unsigned S_DATA_COUNT   = 2,
  parameter int unsigned T_DATA_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned T_ID___WIDTH  = $clog2(S_DATA_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [T_ID___WIDTH-1:0] grant_id_i,
  input  logic                    grant_valid_i,
  output logic [S_DATA_COUNT-1:0] last_o,
  input  logic [T_DATA_WIDTH-1:0] s_tdata_i [S_DATA_COUNT],
  input  logic [S_DATA_COUNT-1:0] s_tvalid_i,
  input  logic [S_DATA_COUNT-1:0] s_tlast_i,
  output logic [S_DATA_COUNT-1:0] s_tready_o,
  output logic [T_DATA_WIDTH-1:0] m_tdata_o,
  output logic                    m_tvalid_o,
  output logic                    m_tlast_o,
  output logic [T_ID___WIDTH-1:0] m_tid_o,
`ifdef STREAM_OUT_MUX_WATCHDOG_EN
  output logic                    err_o,
`endif
  input  logic                    m_tready_i
);

  if (S_DATA_COUNT < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("stream_out_mux: S_DATA_COUNT must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  typedef struct packed {
    logic [T_ID___WIDTH-1:0] id;
    logic                    last;
    logic [T_DATA_WIDTH-1:0] data;
  } beat_t;

  state_e                  state_q;
  logic [T_ID___WIDTH-1:0] lock_id_q;
  beat_t                   main_q, main_d, skid_q, skid_d;
  logic                    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  beat_t                   in_beat;
  logic                    in_vld, accept, consume, pkt_done, wd_fire;

  assign in_vld   = s_tvalid_i[lock_id_q];
  assign accept   = (state_q == LOCK) && in_vld && !skid_vld_q;
  assign consume  = main_vld_q && m_tready_i;
  assign in_beat  = {lock_id_q, s_tlast_i[lock_id_q], s_tdata_i[lock_id_q]};
  assign pkt_done = (accept && s_tlast_i[lock_id_q]) || wd_fire;

  always_comb begin
    s_tready_o = '0;
    last_o     = '0;
    if (state_q == LOCK) s_tready_o[lock_id_q] = !skid_vld_q;
    if (pkt_done) last_o[lock_id_q] = 1'b1;
  end

  // Skid only fills while main is stalled, so skid valid implies main valid.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (consume) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_beat;
      end
    end else if (accept) begin
      if (main_vld_q) begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid_i) begin
            lock_id_q <= grant_id_i;
            state_q   <= LOCK;
          end
        end
        LOCK: begin
          if (pkt_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_tdata_o  = main_q.data;
  assign m_tlast_o  = main_q.last;
  assign m_tid_o    = main_q.id;
  assign m_tvalid_o = main_vld_q;

`ifdef STREAM_OUT_MUX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;

  // Down-counter of remaining silent LOCK cycles; fires on the last one.
  assign wd_fire = (state_q == LOCK) && !in_vld && (wd_cnt_q == WD_W'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      wd_cnt_q <= WD_W'(TIMEOUT_CYCLES);
      err_q    <= 1'b0;
    end else begin
      if (state_q != LOCK || accept || wd_fire) wd_cnt_q <= WD_W'(TIMEOUT_CYCLES);
      else if (!in_vld) wd_cnt_q <= wd_cnt_q - WD_W'(1);
      if (wd_fire) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_stream_out_mux.sv
// Bench for stream_out_mux: fixed vector table, directed corner sequences and random traffic,
// all checked against a queue-based transaction model of the output stage.
module tb_stream_out_mux;
  localparam int S  = 2;
  localparam int W  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:0]   gid;
  logic         gv;
  logic [S-1:0] last_o;
  logic [W-1:0] sd [S];
  logic [S-1:0] sv, sl, srdy;
  logic [W-1:0] md;
  logic         mv, ml, mr;
  logic [0:0]   m_tid;
`ifdef STREAM_OUT_MUX_WATCHDOG_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  stream_out_mux #(.S_DATA_COUNT(S), .T_DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_in(rst_n), .grant_id_i(gid), .grant_valid_i(gv), .last_o(last_o),
    .s_tdata_i(sd), .s_tvalid_i(sv), .s_tlast_i(sl), .s_tready_o(srdy),
    .m_tdata_o(md), .m_tvalid_o(mv), .m_tlast_o(ml), .m_tid_o(m_tid),
`ifdef STREAM_OUT_MUX_WATCHDOG_EN
    .err_o(err),
`endif
    .m_tready_i(mr)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endfunction

  // Transaction model: locked flag, lock id, FIFO of up to two buffered beats.
  typedef struct { int id; logic [31:0] d; bit l; } beat_t;
  beat_t mq[$];
  bit    mlock = 0;
  int    mlk   = 0;
  int    midle = 0;
  bit    merr  = 0;

  beat_t out_log[$];
  beat_t src0[$], src1[$];
  logic [S-1:0] acc_src;

  logic [S-1:0] smp_rdy, smp_last;
  logic [W-1:0] smp_md;
  logic         smp_mv, smp_err;

  // Called at posedge+1 with inputs set; samples mid-cycle, advances model, returns at next posedge+1.
  task automatic step();
    bit acc, fire;
    logic [S-1:0] exp_rdy, exp_last;
    #4;
    acc  = mlock && sv[mlk] && (mq.size() < 2);
    fire = 1'b0;
`ifdef STREAM_OUT_MUX_WATCHDOG_EN
    fire = mlock && !sv[mlk] && (midle == TO - 1);
`endif
    exp_rdy  = (mlock && mq.size() < 2) ? S'(1 << mlk) : '0;
    exp_last = ((acc && sl[mlk]) || fire) ? S'(1 << mlk) : '0;
    chk("s_tready", srdy, exp_rdy);
    chk("last_o", last_o, exp_last);
    chk("m_tvalid", mv, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_tdata", md, mq[0].d);
      chk("m_tlast", ml, mq[0].l);
      chk("m_tid", m_tid, mq[0].id);
    end
    smp_err = 1'b0;
`ifdef STREAM_OUT_MUX_WATCHDOG_EN
    chk("err_o", err, merr);
    smp_err = err;
`endif
    smp_rdy = srdy; smp_last = last_o; smp_md = md; smp_mv = mv;
    acc_src = sv & srdy;
    if (mv && mr) out_log.push_back('{int'(m_tid), md, ml});
    if (!rst_n) begin
      mq.delete(); mlock = 0; midle = 0; merr = 0;
    end else begin
      if (mq.size() > 0 && mr) void'(mq.pop_front());
      if (acc) mq.push_back('{mlk, sd[mlk], sl[mlk]});
      if (!mlock) begin
        midle = 0;
        if (gv) begin mlock = 1; mlk = int'(gid); end
      end else if ((acc && sl[mlk]) || fire) begin
        mlock = 0; midle = 0;
        if (fire) merr = 1;
      end else if (acc) midle = 0;
      else if (!sv[mlk]) midle++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_src();
    sv = '0; sl = '0; sd[0] = 32'hDEAD_0000; sd[1] = 32'hDEAD_0001;
    if (src0.size() > 0) begin sv[0] = 1'b1; sd[0] = src0[0].d; sl[0] = src0[0].l; end
    if (src1.size() > 0) begin sv[1] = 1'b1; sd[1] = src1[0].d; sl[1] = src1[0].l; end
  endtask

  task automatic cyc(input bit g_v, input bit g_id, input bit m_r);
    gv = g_v; gid = g_id; mr = m_r;
    drive_src();
    step();
    if (acc_src[0]) void'(src0.pop_front());
    if (acc_src[1]) void'(src1.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  function automatic void check_log(string name, beat_t exp_q[$]);
    chk({name, "_count"}, out_log.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < out_log.size()) begin
        chk({name, "_id"}, out_log[i].id, exp_q[i].id);
        chk({name, "_data"}, out_log[i].d, exp_q[i].d);
        chk({name, "_last"}, out_log[i].l, exp_q[i].l);
      end
    end
  endfunction

  typedef struct {
    bit gv; bit gid; logic [1:0] sv; logic [1:0] sl; logic [31:0] d1; bit mr;
    logic [1:0] e_rdy; bit e_mv; logic [31:0] e_md; bit e_ml; bit e_tid; logic [1:0] e_last;
  } vec_t;
  vec_t tbl [7];

  beat_t exp_q[$];

  initial begin
    tbl[0] = '{1, 1, 2'b00, 2'b00, 32'h0,  1, 2'b00, 0, 32'h0,  0, 0, 2'b00};
    tbl[1] = '{0, 1, 2'b10, 2'b00, 32'hA0, 1, 2'b10, 0, 32'h0,  0, 0, 2'b00};
    tbl[2] = '{0, 1, 2'b10, 2'b00, 32'hA1, 1, 2'b10, 1, 32'hA0, 0, 1, 2'b00};
    tbl[3] = '{0, 1, 2'b10, 2'b00, 32'hA2, 1, 2'b10, 1, 32'hA1, 0, 1, 2'b00};
    tbl[4] = '{0, 1, 2'b10, 2'b10, 32'hA3, 1, 2'b10, 1, 32'hA2, 0, 1, 2'b10};
    tbl[5] = '{0, 1, 2'b00, 2'b00, 32'h0,  1, 2'b00, 1, 32'hA3, 1, 1, 2'b00};
    tbl[6] = '{0, 1, 2'b00, 2'b00, 32'h0,  1, 2'b00, 0, 32'h0,  0, 0, 2'b00};

    rst_n = 1'b0; gv = 1'b0; gid = '0; sv = '0; sl = '0; mr = 1'b1;
    sd[0] = '0; sd[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single packet from master 1, vectors with hand-derived expectations
    foreach (tbl[i]) begin
      gv = tbl[i].gv; gid = tbl[i].gid; sv = tbl[i].sv; sl = tbl[i].sl;
      sd[0] = 32'h55; sd[1] = tbl[i].d1; mr = tbl[i].mr;
      step();
      chk("tbl_rdy", smp_rdy, tbl[i].e_rdy);
      chk("tbl_mv", smp_mv, tbl[i].e_mv);
      chk("tbl_last", smp_last, tbl[i].e_last);
      if (tbl[i].e_mv) chk("tbl_md", smp_md, tbl[i].e_md);
      if (i == 0) begin
        chk("rst_tdata", md, 0);
        chk("rst_tlast", ml, 0);
        chk("rst_tid", m_tid, 0);
      end
    end

    // Backpressure: 3 stalled cycles mid-packet fill both entries
    out_log.delete();
    for (int i = 0; i < 6; i++) src0.push_back('{0, 32'hC0 + i, i == 5});
    cyc(1, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(0, 0, 0); chk("bp_hold_a", smp_md, 32'hC1);
    cyc(0, 0, 0); chk("bp_full_rdy_a", smp_rdy, 0); chk("bp_hold_b", smp_md, 32'hC1);
    cyc(0, 0, 0); chk("bp_full_rdy_b", smp_rdy, 0); chk("bp_hold_c", smp_md, 32'hC1);
    idle(10);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back('{0, 32'hC0 + i, i == 5});
    check_log("bp", exp_q);
    chk("bp_src_drained", src0.size(), 0);

    // Back-to-back packets: grant 0 then 1, master-0 tail drains while master 1 locks
    out_log.delete();
    src0.push_back('{0, 32'hD0, 0}); src0.push_back('{0, 32'hD1, 1});
    for (int i = 0; i < 3; i++) src1.push_back('{1, 32'hE0 + i, i == 2});
    cyc(1, 0, 1); cyc(1, 1, 1);
    cyc(1, 1, 0); chk("b2b_last0", smp_last, 2'b01);
    cyc(1, 1, 0); chk("b2b_idle_rdy", smp_rdy, 0); chk("b2b_idle_last", smp_last, 0);
    cyc(1, 1, 0); cyc(0, 1, 1);
    idle(10);
    exp_q.delete();
    exp_q.push_back('{0, 32'hD0, 0}); exp_q.push_back('{0, 32'hD1, 1});
    for (int i = 0; i < 3; i++) exp_q.push_back('{1, 32'hE0 + i, i == 2});
    check_log("b2b", exp_q);

    // Non-granted master 0 holds valid while locked on master 1
    out_log.delete();
    src0.push_back('{0, 32'hBAD0, 1});
    for (int i = 0; i < 3; i++) src1.push_back('{1, 32'hF0 + i, i == 2});
    cyc(1, 1, 1); chk("ng_rdy0_first", smp_rdy[0], 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1);
      chk("ng_rdy0", smp_rdy[0], 0);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{1, 32'hF0 + i, i == 2});
    check_log("ng", exp_q);
    src0.delete();
    idle(3);

    // Reset while both entries hold beats
    for (int i = 0; i < 4; i++) src0.push_back('{0, 32'h70 + i, 0});
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0); chk("rst_pre_full_rdy", smp_rdy, 0); chk("rst_pre_mv", smp_mv, 1);
    rst_n = 1'b0; cyc(0, 0, 0); rst_n = 1'b1;
    cyc(0, 0, 1); chk("rst_mv", smp_mv, 0); chk("rst_rdy", smp_rdy, 0);
    src0.delete();
    idle(3);

`ifdef STREAM_OUT_MUX_WATCHDOG_EN
    // Master 0 goes silent after one beat; lock released on the 4th silent cycle
    src0.push_back('{0, 32'h6000_0000, 0});
    cyc(1, 0, 1); cyc(0, 0, 1);
    repeat (3) begin cyc(0, 0, 1); chk("wd_no_last", smp_last, 0); end
    cyc(0, 0, 1); chk("wd_last", smp_last, 2'b01); chk("wd_err_pre", smp_err, 0);
    cyc(0, 0, 1); chk("wd_err", smp_err, 1); chk("wd_idle_rdy", smp_rdy, 0);
    repeat (3) begin cyc(0, 0, 1); chk("wd_err_sticky", smp_err, 1); end
`endif

    // Random traffic against the model
    for (int c = 0; c < 2500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      gv    = ($urandom_range(0, 3) != 0);
      gid   = 1'($urandom_range(0, 1));
      sv    = 2'($urandom_range(0, 3));
      sl[0] = ($urandom_range(0, 3) == 0);
      sl[1] = ($urandom_range(0, 3) == 0);
      sd[0] = $urandom;
      sd[1] = $urandom;
      mr    = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
